uart_tx: RTL and testbench

UART transmitter for the serial link, the send-side counterpart of the existing 8N1 receive path. It accepts bytes over a valid/ready handshake and buffers them in a small FIFO. Each byte is serialised LSB-first as one start bit, eight data bits and P_STOP_BITS stop bits on an idle-high line. Bit timing matches the receiver's bit period, so a transmitter looped back into the receiver recovers every byte.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_tx_fifo.sv | 49 ++++
 rtl/uart_tx.sv | 153 +++++++++++++++
 tb/tb_uart_tx.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and link timing constants
// common to the send and receive paths.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int C_UART_CLK_PER_BIT = 2084;
  localparam int C_UART_DATA_BITS   = 8;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter. Pointers carry one extra wrap bit so
// that full and empty are distinguished without a separate occupancy count.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int P_FIFO_DEPTH = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rstn,
  input  logic                        push,
  input  logic [C_UART_DATA_BITS-1:0] wdata,
  input  logic                        pop,
  output logic [C_UART_DATA_BITS-1:0] rdata,
  output logic                        full,
  output logic                        empty
);

  localparam int AW = $clog2(P_FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [C_UART_DATA_BITS-1:0] mem [P_FIFO_DEPTH];
  logic [AW:0]                 wr_ptr;
  logic [AW:0]                 rd_ptr;
  logic                        do_push;
  logic                        do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage needs no reset: the pointers alone decide what is valid.
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/uart_tx.sv
// 8N1-style UART transmitter: bytes queue in a small FIFO and are sent LSB
// first with a start bit and P_STOP_BITS stop bits on an idle-high line.
module uart_tx
  import uart_pkg::*;
#(
  parameter int P_CLK_PER_BIT = C_UART_CLK_PER_BIT,
  parameter int P_FIFO_DEPTH  = 4,
  parameter int P_STOP_BITS   = 1
) (
  input  logic                        i_clk,
  input  logic                        i_rstn,
  input  logic [C_UART_DATA_BITS-1:0] i_tx_data,
  input  logic                        i_tx_valid,
  output logic                        o_tx_ready,
  output logic                        o_tx,
  output logic                        o_tx_busy,
  output logic                        o_tx_done,
  output logic                        o_led_tx
);

  localparam int CW = $clog2(P_CLK_PER_BIT);
  localparam int IW = $clog2(C_UART_DATA_BITS);

  tx_state_e                   state_q, state_d;
  logic [CW-1:0]               bit_cnt_q, bit_cnt_d;
  logic [IW-1:0]               bit_idx_q, bit_idx_d;
  logic [1:0]                  stop_cnt_q, stop_cnt_d;
  logic [C_UART_DATA_BITS-1:0] r_shift, shift_d;
  logic                        tx_q, tx_d;
  logic                        led_q;
  logic                        done;
  logic                        bit_end;
  logic                        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [C_UART_DATA_BITS-1:0] fifo_rdata;

  assign fifo_push = i_tx_valid && !fifo_full;

  uart_tx_fifo #(
    .P_FIFO_DEPTH(P_FIFO_DEPTH)
  ) u_fifo (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .push   (fifo_push),
    .wdata  (i_tx_data),
    .pop    (fifo_pop),
    .rdata  (fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign bit_end = (bit_cnt_q == CW'(P_CLK_PER_BIT - 1));

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    bit_idx_d  = bit_idx_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = r_shift;
    fifo_pop   = 1'b0;
    done       = 1'b0;
    tx_d       = 1'b1;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          shift_d   = fifo_rdata;
          bit_cnt_d = '0;
          state_d   = START;
        end
      end
      START: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = DATA;
        end else begin
          bit_cnt_d = bit_cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          shift_d   = r_shift >> 1;
          if (bit_idx_q == IW'(C_UART_DATA_BITS - 1)) begin
            stop_cnt_d = '0;
            state_d    = STOP;
          end else begin
            bit_idx_d = bit_idx_q + IW'(1);
          end
        end else begin
          bit_cnt_d = bit_cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          if (stop_cnt_q == 2'(P_STOP_BITS - 1)) begin
            done       = 1'b1;
            stop_cnt_d = '0;
            // Chain straight into the next start bit when more data is queued.
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              shift_d  = fifo_rdata;
              state_d  = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            stop_cnt_d = stop_cnt_q + 2'd1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level follows the state being entered, so it moves only on bit boundaries.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      bit_idx_q  <= '0;
      stop_cnt_q <= '0;
      r_shift    <= '0;
      tx_q       <= 1'b1;
      led_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_idx_q  <= bit_idx_d;
      stop_cnt_q <= stop_cnt_d;
      r_shift    <= shift_d;
      tx_q       <= tx_d;
      led_q      <= (state_d != IDLE);
    end
  end

  assign o_tx       = tx_q;
  assign o_tx_ready = !fifo_full;
  assign o_tx_busy  = (state_q != IDLE);
  assign o_tx_done  = done;
  assign o_led_tx   = led_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: default-timing frame, a table of short-bit-period
// frames, burst/backpressure sequences, mid-frame resets and two stop bits.
module tb_uart_tx;

  localparam int CPB_A = 2084;
  localparam int CPB_B = 16;

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn_a, rstn_b, rstn_c;
  logic [7:0] data;
  logic       valid_a, valid_b, valid_c;
  logic       ready_a, ready_b, ready_c;
  logic       tx_a, tx_b, tx_c;
  logic       busy_a, busy_b, busy_c;
  logic       done_a, done_b, done_c;
  logic       led_a, led_b, led_c;

  int checks = 0;
  int failures = 0;

  uart_tx dut_a (
    .i_clk(clk), .i_rstn(rstn_a), .i_tx_data(data), .i_tx_valid(valid_a),
    .o_tx_ready(ready_a), .o_tx(tx_a), .o_tx_busy(busy_a), .o_tx_done(done_a), .o_led_tx(led_a)
  );

  uart_tx #(.P_CLK_PER_BIT(CPB_B)) dut_b (
    .i_clk(clk), .i_rstn(rstn_b), .i_tx_data(data), .i_tx_valid(valid_b),
    .o_tx_ready(ready_b), .o_tx(tx_b), .o_tx_busy(busy_b), .o_tx_done(done_b), .o_led_tx(led_b)
  );

  uart_tx #(.P_STOP_BITS(2)) dut_c (
    .i_clk(clk), .i_rstn(rstn_c), .i_tx_data(data), .i_tx_valid(valid_c),
    .o_tx_ready(ready_c), .o_tx(tx_c), .o_tx_busy(busy_c), .o_tx_done(done_c), .o_led_tx(led_c)
  );

  function automatic logic tx_of(input int w);
    return (w == 0) ? tx_a : (w == 1) ? tx_b : tx_c;
  endfunction
  function automatic logic ready_of(input int w);
    return (w == 0) ? ready_a : (w == 1) ? ready_b : ready_c;
  endfunction
  function automatic logic busy_of(input int w);
    return (w == 0) ? busy_a : (w == 1) ? busy_b : busy_c;
  endfunction
  function automatic logic done_of(input int w);
    return (w == 0) ? done_a : (w == 1) ? done_b : done_c;
  endfunction
  function automatic logic led_of(input int w);
    return (w == 0) ? led_a : (w == 1) ? led_b : led_c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_valid(input int w, input logic v);
    if (w == 0) valid_a = v;
    else if (w == 1) valid_b = v;
    else valid_c = v;
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic push(input int w, input logic [7:0] d, input int budget, output int waited);
    waited = 0;
    data = d;
    set_valid(w, 1'b1);
    while (ready_of(w) !== 1'b1 && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    @(posedge clk);
    @(negedge clk);
    set_valid(w, 1'b0);
  endtask

  // Waits for a start bit, then checks every cycle of one frame against the
  // hand-written line pattern {stop, data[7:0], start}; returns the idle cycles seen first.
  task automatic check_frame(input int w, input int cpb, input int stops, input logic [9:0] line,
                             input string name, output int gap);
    int flen, mism, dcnt, dpos, j;
    logic [7:0] rx;
    logic ferr, exp_tx;
    flen = (9 + stops) * cpb;
    mism = 0; dcnt = 0; dpos = -1; rx = '0; ferr = 1'b0; gap = 0;
    @(negedge clk);
    while (tx_of(w) !== 1'b0 && gap < 2 * flen) begin
      @(negedge clk);
      gap++;
    end
    check({name, "_start"}, 32'(gap < 2 * flen), 32'd1);
    if (gap >= 2 * flen) return;
    for (int k = 0; k < flen; k++) begin
      if (k > 0) @(negedge clk);
      j = k / cpb;
      if (j <= 9) exp_tx = line[j];
      else exp_tx = 1'b1;
      if (tx_of(w) !== exp_tx) mism++;
      if (busy_of(w) !== 1'b1 || led_of(w) !== busy_of(w)) mism++;
      if (done_of(w) === 1'b1) begin
        dcnt++;
        dpos = k;
      end
      if (k % cpb == cpb / 2) begin
        if (j == 0) begin
          if (tx_of(w) !== 1'b0) ferr = 1'b1;
        end else if (j <= 8) begin
          rx[j-1] = tx_of(w);
        end else if (tx_of(w) !== 1'b1) begin
          ferr = 1'b1;
        end
      end
    end
    check({name, "_line"}, mism, 0);
    check({name, "_done_cnt"}, dcnt, 1);
    check({name, "_done_pos"}, dpos, flen - 1);
    check({name, "_rx"}, {ferr, rx}, {1'b0, line[8:1]});
  endtask

  initial begin
    #(200000 * 10);
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv[15];
    int   w, gap, mism, dn;
    tv[0]  = '{8'h55, 10'b1010101010};
    tv[1]  = '{8'hA3, 10'b1101000110};
    tv[2]  = '{8'h00, 10'b1000000000};
    tv[3]  = '{8'hFF, 10'b1111111110};
    tv[4]  = '{8'h80, 10'b1100000000};
    tv[5]  = '{8'h01, 10'b1000000010};
    tv[6]  = '{8'h02, 10'b1000000100};
    tv[7]  = '{8'h03, 10'b1000000110};
    tv[8]  = '{8'h04, 10'b1000001000};
    tv[9]  = '{8'h10, 10'b1000100000};
    tv[10] = '{8'h11, 10'b1000100010};
    tv[11] = '{8'h12, 10'b1000100100};
    tv[12] = '{8'h13, 10'b1000100110};
    tv[13] = '{8'h14, 10'b1000101000};
    tv[14] = '{8'h15, 10'b1000101010};

    rstn_a = 1'b0; rstn_b = 1'b0; rstn_c = 1'b0;
    valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0;
    data = '0;
    repeat (3) @(negedge clk);
    check("rst_a", {tx_a, ready_a, busy_a, done_a, led_a}, 5'b11000);
    check("rst_b", {tx_b, ready_b, busy_b, done_b, led_b}, 5'b11000);
    check("rst_c", {tx_c, ready_c, busy_c, done_c, led_c}, 5'b11000);
    rstn_a = 1'b1; rstn_b = 1'b1; rstn_c = 1'b1;
    @(negedge clk);

    // Default bit period, byte 0x55.
    push(0, 8'h55, 4, w);
    check("a_push_wait", w, 0);
    check("a_idle_before_start", tx_a, 1'b1);
    check_frame(0, CPB_A, 1, tv[0].line, "a55", gap);
    check("a55_latency", gap, 0);
    @(negedge clk);
    check("a55_after", {tx_a, busy_a, done_a, led_a}, 4'b1000);

    // Single-frame vector table on the short-bit-period instance.
    for (int i = 0; i < 5; i++) begin
      push(1, tv[i].data, 4, w);
      check($sformatf("b_push_wait_%0d", i), w, 0);
      check_frame(1, CPB_B, 1, tv[i].line, $sformatf("b_vec%0d", i), gap);
      check($sformatf("b_latency_%0d", i), gap, 0);
      @(negedge clk);
      check($sformatf("b_after_%0d", i), {tx_b, busy_b, done_b, led_b}, 4'b1000);
    end

    // Four bytes on consecutive cycles: no idle gap between frames.
    fork
      begin
        for (int i = 5; i < 9; i++) begin
          push(1, tv[i].data, 4, w);
          check($sformatf("burst_ready_%0d", i), w, 0);
        end
      end
      begin
        for (int i = 5; i < 9; i++) begin
          check_frame(1, CPB_B, 1, tv[i].line, $sformatf("burst%0d", i), gap);
          if (i > 5) check($sformatf("burst_gap_%0d", i), gap, 0);
        end
      end
    join
    @(negedge clk);
    check("burst_after", {tx_b, busy_b, ready_b}, 3'b101);

    // Fill the FIFO behind a running frame; the sixth push must wait for a pop.
    fork
      begin
        push(1, tv[9].data, 4, w);
        for (int i = 10; i < 14; i++) begin
          push(1, tv[i].data, 4, w);
          check($sformatf("fill_ready_%0d", i), w, 0);
        end
        check("full_ready_low", ready_b, 1'b0);
        push(1, tv[14].data, 400, w);
        check("fifth_held_off", 32'(w > 0 && w < 400), 32'd1);
      end
      begin
        for (int i = 9; i < 15; i++) begin
          check_frame(1, CPB_B, 1, tv[i].line, $sformatf("order%0d", i), gap);
          if (i > 9) check($sformatf("order_gap_%0d", i), gap, 0);
        end
      end
    join
    @(negedge clk);
    check("order_after", {tx_b, busy_b, ready_b}, 3'b101);

    // Reset during data bit 3 of 0xFF with two more bytes queued.
    push(1, 8'hFF, 4, w);
    push(1, 8'h21, 4, w);
    push(1, 8'h22, 4, w);
    repeat (71) @(negedge clk);
    check("pre_rst_busy", busy_b, 1'b1);
    #1 rstn_b = 1'b0;
    #1 check("rst_mid_async", {tx_b, ready_b, busy_b, done_b, led_b}, 5'b11000);
    @(negedge clk);
    rstn_b = 1'b1;
    mism = 0; dn = 0;
    for (int k = 0; k < 3 * CPB_B; k++) begin
      @(negedge clk);
      if (tx_b !== 1'b1 || busy_b !== 1'b0 || ready_b !== 1'b1) mism++;
      if (done_b === 1'b1) dn++;
    end
    check("rst_idle_line", mism, 0);
    check("rst_no_done", dn, 0);

    // Reset while the start bit is driving the line low.
    push(1, 8'h00, 4, w);
    @(negedge clk);
    check("pre_rst2_low", tx_b, 1'b0);
    #1 rstn_b = 1'b0;
    #1 check("rst_start_async", {tx_b, busy_b, led_b}, 3'b100);
    @(negedge clk);
    rstn_b = 1'b1;
    repeat (2 * CPB_B) @(negedge clk);
    check("rst2_idle", {tx_b, busy_b, ready_b}, 3'b101);

    // Two stop bits at the default bit period, byte 0x00.
    push(2, 8'h00, 4, w);
    check("c_push_wait", w, 0);
    check_frame(2, CPB_A, 2, tv[2].line, "c_stop2", gap);
    check("c_latency", gap, 0);
    @(negedge clk);
    check("c_after", {tx_c, busy_c, done_c}, 3'b100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
